// File: rtl/axi_wr_txn_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_wr_txn_arbiter_pkg
//   Shared AXI scheduling definitions.
//   - AXI_POINTER_BITS : width of every channel mux select.
//   - pointer_t        : mux select value (DEFAULT = nobody selected).
//   - wr_state_t       : write transaction phase.
//   - rr_pick()        : two-way round-robin choice. It is kept here so the
//                        read-side scheduler can use the same fairness rule.
// ---------------------------------------------------------------------------
package axi_wr_txn_arbiter_pkg;

    localparam int AXI_POINTER_BITS = 2;

    typedef enum logic [AXI_POINTER_BITS-1:0] {
        DEFAULT = 2'd0,
        SEL0    = 2'd1,
        SEL1    = 2'd2
    } pointer_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wr_state_t;

    // When both masters request, the one not served last goes first.
    // After reset (last == DEFAULT), m0 has priority.
    function automatic pointer_t rr_pick(input logic v0, input logic v1, input pointer_t last);
        pointer_t pick;
        pick = DEFAULT;
        if (v0 && v1) begin
            pick = (last == SEL0) ? SEL1 : SEL0;
        end else if (v0) begin
            pick = SEL0;
        end else if (v1) begin
            pick = SEL1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_wr_txn_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_txn_arbiter
//   Write-path transaction scheduler for a shared AXI slave port. It grants one
//   of two masters in round-robin order and holds that grant for the whole
//   write transaction: the AW handshake, every W beat up to WLAST, and the B
//   response. It also flags burst-length mismatches and aborts a transaction
//   that stalls for too long in the data or response phase.
//
//   Inputs : ACLK, ARESETn (async, active low), m0_awvalid/m1_awvalid
//            (requests), awlen, aw_hs/w_hs/b_hs (slave-side handshakes),
//            wlast, err_clr
//   Outputs: aw_sel/w_sel/b_sel (mux selects, DEFAULT when the channel is
//            closed), busy, err_len and err_to (sticky error flags)
//
//   Every output is a flop or a decode of flops, so there is no
//   combinational path from any input to any output.
// ---------------------------------------------------------------------------
module axi_wr_txn_arbiter
    import axi_wr_txn_arbiter_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        m0_awvalid,
    input  logic                        m1_awvalid,
    input  logic [LEN_W-1:0]            awlen,
    input  logic                        aw_hs,
    input  logic                        w_hs,
    input  logic                        wlast,
    input  logic                        b_hs,
    input  logic                        err_clr,
    output logic [AXI_POINTER_BITS-1:0] aw_sel,
    output logic [AXI_POINTER_BITS-1:0] w_sel,
    output logic [AXI_POINTER_BITS-1:0] b_sel,
    output logic                        busy,
    output logic                        err_len,
    output logic                        err_to
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    wr_state_t        state_q, state_d;
    pointer_t         grant_q, grant_d;
    pointer_t         last_grant_q, last_grant_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             err_len_q, err_len_d;
    logic             err_to_q, err_to_d;
    logic             len_mismatch;
    logic             timeout_hit;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        to_cnt_d     = '0;
        len_mismatch = 1'b0;
        timeout_hit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_awvalid || m1_awvalid) begin
                    grant_d = rr_pick(m0_awvalid, m1_awvalid, last_grant_q);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    len_d      = awlen;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                    // beat_cnt_q is the 0-based index of the current beat,
                    // so the final beat must carry index len_q.
                    if (wlast) begin
                        len_mismatch = (beat_cnt_q != len_q);
                        state_d      = RESP;
                    end else if (beat_cnt_q == len_q) begin
                        len_mismatch = 1'b1;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    last_grant_d = grant_q;
                    grant_d      = DEFAULT;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The watchdog only runs while waiting on data or the response, and
        // restarts on any handshake or phase change. The address phase is
        // exempt because AWVALID must stay asserted until it is accepted.
        if ((state_q == DATA || state_q == RESP) && state_d == state_q && !w_hs && !b_hs) begin
            if (to_cnt_q == TO_LAST) begin
                timeout_hit  = 1'b1;
                last_grant_d = grant_q;
                grant_d      = DEFAULT;
                state_d      = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        // A new error in the same cycle as a clear keeps the flag set.
        err_len_d = len_mismatch ? 1'b1 : (err_clr ? 1'b0 : err_len_q);
        err_to_d  = timeout_hit  ? 1'b1 : (err_clr ? 1'b0 : err_to_q);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            grant_q      <= DEFAULT;
            last_grant_q <= DEFAULT;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            to_cnt_q     <= '0;
            err_len_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            to_cnt_q     <= to_cnt_d;
            err_len_q    <= err_len_d;
            err_to_q     <= err_to_d;
        end
    end

    // Each select shows the grant only while its own channel is open.
    assign aw_sel  = (state_q == ADDR) ? grant_q : DEFAULT;
    assign w_sel   = (state_q == DATA) ? grant_q : DEFAULT;
    assign b_sel   = (state_q == RESP) ? grant_q : DEFAULT;
    assign busy    = (state_q != IDLE);
    assign err_len = err_len_q;
    assign err_to  = err_to_q;

endmodule

// File: tb/tb_axi_wr_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_txn_arbiter
//   Self-checking bench for axi_wr_txn_arbiter (TIMEOUT = 8). A transaction-
//   level reference model predicts the outputs every cycle from the arbitration
//   rules. A set of directed scenarios pins the model to hand-computed values,
//   and a long randomized run exercises the remaining input combinations.
// ---------------------------------------------------------------------------
module tb_axi_wr_txn_arbiter;
    import axi_wr_txn_arbiter_pkg::*;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 8;

    logic             ACLK       = 1'b0;
    logic             ARESETn    = 1'b1;
    logic             m0_awvalid = 1'b0;
    logic             m1_awvalid = 1'b0;
    logic [LEN_W-1:0] awlen      = '0;
    logic             aw_hs      = 1'b0;
    logic             w_hs       = 1'b0;
    logic             wlast      = 1'b0;
    logic             b_hs       = 1'b0;
    logic             err_clr    = 1'b0;
    logic [1:0]       aw_sel, w_sel, b_sel;
    logic             busy, err_len, err_to;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    axi_wr_txn_arbiter #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .m0_awvalid (m0_awvalid),
        .m1_awvalid (m1_awvalid),
        .awlen      (awlen),
        .aw_hs      (aw_hs),
        .w_hs       (w_hs),
        .wlast      (wlast),
        .b_hs       (b_hs),
        .err_clr    (err_clr),
        .aw_sel     (aw_sel),
        .w_sel      (w_sel),
        .b_sel      (b_sel),
        .busy       (busy),
        .err_len    (err_len),
        .err_to     (err_to)
    );

    always #5 ACLK = ~ACLK;

    // Reference model. The phase variable counts through the transaction:
    // 0 waiting for a request, 1 address, 2 data, 3 response.
    int       m_phase;
    pointer_t m_grant;
    pointer_t m_last;
    int       m_len;
    int       m_beats;
    int       m_quiet;
    bit       m_err_len;
    bit       m_err_to;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_phase   = 0;
            m_grant   = DEFAULT;
            m_last    = DEFAULT;
            m_len     = 0;
            m_beats   = 0;
            m_quiet   = 0;
            m_err_len = 1'b0;
            m_err_to  = 1'b0;
        end else begin : model_step
            int next_phase;
            bit new_len_err;
            bit new_to_err;
            next_phase  = m_phase;
            new_len_err = 1'b0;
            new_to_err  = 1'b0;
            if (m_phase == 0) begin
                if (m0_awvalid && m1_awvalid) begin
                    m_grant    = (m_last == SEL0) ? SEL1 : SEL0;
                    next_phase = 1;
                end else if (m0_awvalid || m1_awvalid) begin
                    m_grant    = m0_awvalid ? SEL0 : SEL1;
                    next_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (aw_hs) begin
                    m_len      = int'(awlen);
                    m_beats    = 0;
                    next_phase = 2;
                end
            end else if (m_phase == 2) begin
                if (w_hs) begin
                    // Burst is (len+1) beats; m_beats beats were already seen.
                    if (wlast) begin
                        new_len_err = (m_beats + 1 != m_len + 1);
                        next_phase  = 3;
                    end else if (m_beats + 1 == m_len + 1) begin
                        new_len_err = 1'b1;
                    end
                    m_beats = (m_beats < 255) ? m_beats + 1 : 255;
                end
            end else begin
                if (b_hs) begin
                    m_last     = m_grant;
                    m_grant    = DEFAULT;
                    next_phase = 0;
                end
            end
            // Count quiet cycles spent waiting in data/response.
            if ((m_phase == 2 || m_phase == 3) && next_phase == m_phase && !w_hs && !b_hs) begin
                if (m_quiet + 1 >= TIMEOUT) begin
                    new_to_err = 1'b1;
                    m_last     = m_grant;
                    m_grant    = DEFAULT;
                    next_phase = 0;
                    m_quiet    = 0;
                end else begin
                    m_quiet = m_quiet + 1;
                end
            end else begin
                m_quiet = 0;
            end
            m_phase = next_phase;
            if (new_len_err) m_err_len = 1'b1;
            else if (err_clr) m_err_len = 1'b0;
            if (new_to_err) m_err_to = 1'b1;
            else if (err_clr) m_err_to = 1'b0;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, mid-cycle.
    always @(negedge ACLK) begin
        if (mon_en) begin
            check("mon_aw_sel", aw_sel, (m_phase == 1) ? m_grant : DEFAULT);
            check("mon_w_sel",  w_sel,  (m_phase == 2) ? m_grant : DEFAULT);
            check("mon_b_sel",  b_sel,  (m_phase == 3) ? m_grant : DEFAULT);
            check("mon_busy",   busy,   8'(m_phase != 0));
            check("mon_err_len", err_len, 8'(m_err_len));
            check("mon_err_to",  err_to,  8'(m_err_to));
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic clear_inputs();
        m0_awvalid = 1'b0;
        m1_awvalid = 1'b0;
        awlen      = '0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        wlast      = 1'b0;
        b_hs       = 1'b0;
        err_clr    = 1'b0;
    endtask

    // Reset takes effect immediately, without waiting for a clock edge.
    task automatic apply_reset();
        clear_inputs();
        ARESETn = 1'b0;
        #1;
        check("rst_busy",    busy,    8'd0);
        check("rst_aw_sel",  aw_sel,  DEFAULT);
        check("rst_w_sel",   w_sel,   DEFAULT);
        check("rst_b_sel",   b_sel,   DEFAULT);
        check("rst_err_len", err_len, 8'd0);
        check("rst_err_to",  err_to,  8'd0);
        repeat (2) @(posedge ACLK);
        #2;
        ARESETn = 1'b1;
    endtask

    task automatic do_txn(input bit r0, input bit r1, input pointer_t exp, input int len,
                          input int nbeats, input int wlast_beat);
        m0_awvalid = r0;
        m1_awvalid = r1;
        tick();
        m0_awvalid = 1'b0;
        m1_awvalid = 1'b0;
        check("txn_aw_sel", aw_sel, exp);
        awlen = LEN_W'(len);
        aw_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        check("txn_w_sel", w_sel, exp);
        for (int i = 1; i <= nbeats; i++) begin
            w_hs  = 1'b1;
            wlast = (i == wlast_beat);
            tick();
        end
        w_hs  = 1'b0;
        wlast = 1'b0;
        check("txn_b_sel", b_sel, exp);
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        check("txn_idle", busy, 8'd0);
    endtask

    task automatic apply_stimulus_random(input int cycles);
        int stall_left;
        stall_left = 0;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 799) == 0) apply_reset();
            if (stall_left == 0 && $urandom_range(0, 59) == 0) stall_left = $urandom_range(6, 12);
            m0_awvalid = 1'($urandom_range(0, 1));
            m1_awvalid = 1'($urandom_range(0, 1));
            awlen      = LEN_W'($urandom_range(0, 3));
            aw_hs      = ($urandom_range(0, 1) == 1);
            wlast      = ($urandom_range(0, 2) == 0);
            err_clr    = ($urandom_range(0, 19) == 0);
            if (stall_left > 0) begin
                w_hs = 1'b0;
                b_hs = 1'b0;
                stall_left--;
            end else begin
                w_hs = ($urandom_range(0, 4) < 3);
                b_hs = ($urandom_range(0, 1) == 1);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        apply_reset();
        mon_en = 1'b1;

        // Single m0 transaction, 4 beats, WLAST on the 4th.
        do_txn(1'b1, 1'b0, SEL0, 3, 4, 4);
        check("t1_err_len", err_len, 8'd0);

        // Both masters request after reset: alternate, starting with m0.
        apply_reset();
        do_txn(1'b1, 1'b1, SEL0, 0, 1, 1);
        do_txn(1'b1, 1'b1, SEL1, 0, 1, 1);
        do_txn(1'b1, 1'b1, SEL0, 1, 2, 2);
        do_txn(1'b1, 1'b1, SEL1, 1, 2, 2);

        // Early WLAST: awlen=3, WLAST on beat 2.
        apply_reset();
        do_txn(1'b1, 1'b0, SEL0, 3, 2, 2);
        check("t3_early_err", err_len, 8'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6_clear", err_len, 8'd0);

        // Late WLAST: awlen=1, WLAST on beat 3.
        m0_awvalid = 1'b1;
        tick();
        m0_awvalid = 1'b0;
        awlen = 8'd1;
        aw_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        w_hs  = 1'b1;
        tick();
        check("t3_beat1_ok", err_len, 8'd0);
        tick();
        check("t3_beat2_err", err_len, 8'd1);
        check("t3_still_data", w_sel, SEL0);
        wlast = 1'b1;
        tick();
        w_hs  = 1'b0;
        wlast = 1'b0;
        check("t3_resp", b_sel, SEL0);
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;

        // err_clr in the same cycle as a new mismatch: the flag stays set.
        m1_awvalid = 1'b1;
        tick();
        m1_awvalid = 1'b0;
        check("t6_grant", aw_sel, SEL1);
        awlen = 8'd0;
        aw_hs = 1'b1;
        tick();
        aw_hs   = 1'b0;
        w_hs    = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6_clear_loses", err_len, 8'd1);
        wlast = 1'b1;
        tick();
        w_hs  = 1'b0;
        wlast = 1'b0;
        b_hs  = 1'b1;
        tick();
        b_hs = 1'b0;

        // Timeout: grant m1, then stall W.
        apply_reset();
        m1_awvalid = 1'b1;
        tick();
        m1_awvalid = 1'b0;
        check("t4_grant_m1", aw_sel, SEL1);
        aw_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check("t4_pre_busy", busy, 8'd1);
        check("t4_pre_err", err_to, 8'd0);
        tick();
        check("t4_err_to", err_to, 8'd1);
        check("t4_idle", busy, 8'd0);
        check("t4_w_sel", w_sel, DEFAULT);
        do_txn(1'b1, 1'b1, SEL0, 0, 1, 1);

        // Reset in the data phase, with err_len already set.
        apply_reset();
        m0_awvalid = 1'b1;
        tick();
        m0_awvalid = 1'b0;
        awlen = 8'd0;
        aw_hs = 1'b1;
        tick();
        aw_hs = 1'b0;
        w_hs  = 1'b1;
        tick();
        w_hs = 1'b0;
        check("t5_pre_err", err_len, 8'd1);
        check("t5_pre_data", w_sel, SEL0);
        apply_reset();
        do_txn(1'b1, 1'b1, SEL0, 0, 1, 1);

        // Randomized traffic checked by the model.
        apply_stimulus_random(4000);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
